// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, and the E/M pipeline register.
// The package carries the datapath width and ALU opcode type shared with decode.

package rv32i_pkg;

   localparam int DPW = 32;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTU = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9
   } alu_op_t;

endpackage

module execute_stage #(
   parameter int DPW = rv32i_pkg::DPW,
   parameter int ADW = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                resultsrcE,
   input  logic                memwriteE,
   input  logic                alusrcE,
   input  logic                regwriteE,
   input  rv32i_pkg::alu_op_t  alu_ctrlE,
   input  logic [DPW-1:0]      srcA,
   input  logic [DPW-1:0]      Rd2E,
   input  logic [ADW-1:0]      RdE,
   input  logic [DPW-1:0]      immextE,
   input  logic [1:0]          fwdA,
   input  logic [1:0]          fwdB,
   input  logic [DPW-1:0]      resultW,
   input  logic                stallM,
   input  logic                flushM,
   output logic                resultsrcM,
   output logic                memwriteM,
   output logic                regwriteM,
   output logic [DPW-1:0]      alu_resultM,
   output logic [DPW-1:0]      writedataM,
   output logic [ADW-1:0]      RdM,
   output logic                zeroE
);

   logic [DPW-1:0] op_a;
   logic [DPW-1:0] writedata;
   logic [DPW-1:0] op_b;
   logic [DPW-1:0] alu_result;
   logic [4:0]     shamt;

   // Reserved select 11 falls through to the register-file operand.
   always_comb begin
      unique case (fwdA)
         2'b01:   op_a = resultW;
         2'b10:   op_a = alu_resultM;
         default: op_a = srcA;
      endcase
   end

   always_comb begin
      unique case (fwdB)
         2'b01:   writedata = resultW;
         2'b10:   writedata = alu_resultM;
         default: writedata = Rd2E;
      endcase
   end

   assign op_b  = alusrcE ? immextE : writedata;
   assign shamt = op_b[4:0];

   always_comb begin
      alu_result = '0;
      case (alu_ctrlE)
         rv32i_pkg::ALU_ADD:  alu_result = op_a + op_b;
         rv32i_pkg::ALU_SUB:  alu_result = op_a - op_b;
         rv32i_pkg::ALU_AND:  alu_result = op_a & op_b;
         rv32i_pkg::ALU_OR:   alu_result = op_a | op_b;
         rv32i_pkg::ALU_XOR:  alu_result = op_a ^ op_b;
         rv32i_pkg::ALU_SLT:  alu_result = {{(DPW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         rv32i_pkg::ALU_SLTU: alu_result = {{(DPW-1){1'b0}}, (op_a < op_b)};
         rv32i_pkg::ALU_SLL:  alu_result = op_a << shamt;
         rv32i_pkg::ALU_SRL:  alu_result = op_a >> shamt;
         rv32i_pkg::ALU_SRA:  alu_result = DPW'($signed(op_a) >>> shamt);
         default:             alu_result = '0;
      endcase
   end

   assign zeroE = (alu_result == '0);

   // Reset and flush both produce a full bubble; flush beats stall.
   always_ff @(posedge clk) begin
      if (rst || flushM) begin
         resultsrcM  <= 1'b0;
         memwriteM   <= 1'b0;
         regwriteM   <= 1'b0;
         alu_resultM <= '0;
         writedataM  <= '0;
         RdM         <= '0;
      end else if (!stallM) begin
         resultsrcM  <= resultsrcE;
         memwriteM   <= memwriteE;
         regwriteM   <= regwriteE;
         alu_resultM <= alu_result;
         writedataM  <= writedata;
         RdM         <= RdE;
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: a behavioural model is checked every cycle,
// and literal expectations at each directed step pin the model as well.

module tb_execute_stage;
   import rv32i_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        resultsrcE = 1'b0, memwriteE = 1'b0, alusrcE = 1'b0, regwriteE = 1'b0;
   alu_op_t     alu_ctrlE = ALU_ADD;
   logic [31:0] srcA = '0, Rd2E = '0, immextE = '0, resultW = '0;
   logic [4:0]  RdE = '0;
   logic [1:0]  fwdA = '0, fwdB = '0;
   logic        stallM = 1'b0, flushM = 1'b0;
   logic        resultsrcM, memwriteM, regwriteM, zeroE;
   logic [31:0] alu_resultM, writedataM;
   logic [4:0]  RdM;

   int total = 0;
   int bad   = 0;
   bit check_en = 1'b0;

   execute_stage #(.DPW(32), .ADW(5)) dut (
      .clk(clk), .rst(rst),
      .resultsrcE(resultsrcE), .memwriteE(memwriteE), .alusrcE(alusrcE), .regwriteE(regwriteE),
      .alu_ctrlE(alu_ctrlE), .srcA(srcA), .Rd2E(Rd2E), .RdE(RdE), .immextE(immextE),
      .fwdA(fwdA), .fwdB(fwdB), .resultW(resultW), .stallM(stallM), .flushM(flushM),
      .resultsrcM(resultsrcM), .memwriteM(memwriteM), .regwriteM(regwriteM),
      .alu_resultM(alu_resultM), .writedataM(writedataM), .RdM(RdM), .zeroE(zeroE)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic        m_rs, m_mw, m_rw;
   logic [31:0] m_alu, m_wd;
   logic [4:0]  m_rd;

   function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                        input logic [31:0] w, input logic [31:0] m);
      if (sel == 2'd1) return w;
      if (sel == 2'd2) return m;
      return rf;
   endfunction

   function automatic logic [31:0] calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int unsigned s;
      s = b % 32;
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         4'd6: return (a < b) ? 32'd1 : 32'd0;
         4'd7: return a * (32'd1 << s);
         4'd8: return a / (33'd1 << s);
         4'd9: return (a / (33'd1 << s)) | ((a[31] && s != 0) ? ~(32'hFFFF_FFFF >> s) : 32'd0);
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] model_alu_now();
      logic [31:0] a, wd;
      a  = pick(fwdA, srcA, resultW, m_alu);
      wd = pick(fwdB, Rd2E, resultW, m_alu);
      return calc(alu_ctrlE, a, alusrcE ? immextE : wd);
   endfunction

   initial begin
      m_rs = 0; m_mw = 0; m_rw = 0; m_alu = '0; m_wd = '0; m_rd = '0;
   end

   always @(posedge clk) begin : model
      logic [31:0] n_alu, n_wd;
      n_alu = model_alu_now();
      n_wd  = pick(fwdB, Rd2E, resultW, m_alu);
      if (rst || flushM) begin
         m_rs = 0; m_mw = 0; m_rw = 0; m_alu = '0; m_wd = '0; m_rd = '0;
      end else if (!stallM) begin
         m_rs = resultsrcE; m_mw = memwriteE; m_rw = regwriteE;
         m_alu = n_alu; m_wd = n_wd; m_rd = RdE;
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("cyc_resultsrcM", 32'(resultsrcM), 32'(m_rs));
         chk("cyc_memwriteM",  32'(memwriteM),  32'(m_mw));
         chk("cyc_regwriteM",  32'(regwriteM),  32'(m_rw));
         chk("cyc_alu_resultM", alu_resultM, m_alu);
         chk("cyc_writedataM", writedataM, m_wd);
         chk("cyc_RdM", 32'(RdM), 32'(m_rd));
         chk("cyc_zeroE", 32'(zeroE), 32'(model_alu_now() == 32'd0));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setop(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic asrc, input logic [31:0] imm);
      alu_ctrlE = op; srcA = a; Rd2E = b; alusrcE = asrc; immextE = imm;
   endtask

   initial begin
      // reset with busy E inputs
      rst = 1; regwriteE = 1; memwriteE = 1; resultsrcE = 1; RdE = 5'd5;
      setop(ALU_ADD, 32'd123, 32'd77, 0, 32'd0);
      tick();
      check_en = 1'b1;
      chk("rst_alu", alu_resultM, 32'd0);
      chk("rst_regwrite", 32'(regwriteM), 32'd0);
      chk("rst_memwrite", 32'(memwriteM), 32'd0);
      chk("rst_rd", 32'(RdM), 32'd0);

      rst = 0; memwriteE = 0; resultsrcE = 0; RdE = 5'd3;
      setop(ALU_ADD, 32'd5, 32'd7, 0, 32'd0);
      #1 chk("add_zeroE", 32'(zeroE), 32'd0);
      tick();
      chk("add_alu", alu_resultM, 32'd12);
      chk("add_rd", 32'(RdM), 32'd3);

      setop(ALU_SUB, 32'd3, 32'd3, 0, 32'd0);
      #1 chk("sub_zeroE", 32'(zeroE), 32'd1);
      tick();
      chk("sub_alu", alu_resultM, 32'd0);

      setop(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 0, 32'd0);
      tick(); chk("slt", alu_resultM, 32'd1);
      setop(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 0, 32'd0);
      tick(); chk("sltu", alu_resultM, 32'd0);
      setop(ALU_SRA, 32'h8000_0000, 32'd0, 1, 32'd4);
      tick(); chk("sra", alu_resultM, 32'hF800_0000);
      setop(ALU_SRL, 32'h8000_0000, 32'd4, 0, 32'd0);
      tick(); chk("srl", alu_resultM, 32'h0800_0000);
      setop(ALU_SLL, 32'h0000_00F1, 32'd36, 0, 32'd0);
      tick(); chk("sll_mod32", alu_resultM, 32'h0000_0F10);
      setop(ALU_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 32'd0);
      tick(); chk("xor", alu_resultM, 32'hFF00_EDCB);
      setop(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 32'd0);
      tick(); chk("and", alu_resultM, 32'h00F0_1234);
      setop(ALU_OR, 32'hF0F0_1234, 32'h0FF0_0000, 0, 32'd0);
      tick(); chk("or", alu_resultM, 32'hFFF0_1234);
      setop(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 0, 32'd0);
      #1 chk("wrap_zeroE", 32'(zeroE), 32'd1);
      tick(); chk("add_wrap", alu_resultM, 32'd0);

      // forwarding
      setop(ALU_ADD, 32'h8, 32'h8, 0, 32'd0);
      tick(); chk("fwd_seed", alu_resultM, 32'h10);
      fwdA = 2'b10; setop(ALU_ADD, 32'h99, 32'h1, 0, 32'd0);
      tick(); chk("fwdA_M", alu_resultM, 32'h11);
      fwdA = 2'b00; fwdB = 2'b01; resultW = 32'h20;
      setop(ALU_ADD, 32'h99, 32'h1, 1, 32'd4);
      tick();
      chk("fwdB_W_wd", writedataM, 32'h20);
      chk("fwdB_W_alu", alu_resultM, 32'h9D);
      fwdA = 2'b11; fwdB = 2'b11;
      setop(ALU_ADD, 32'h40, 32'h2, 0, 32'd0);
      tick();
      chk("fwd_rsv_alu", alu_resultM, 32'h42);
      chk("fwd_rsv_wd", writedataM, 32'h2);
      fwdA = 2'b00; fwdB = 2'b10;
      setop(ALU_SUB, 32'h50, 32'h0, 0, 32'd0);
      tick(); chk("fwdB_M", alu_resultM, 32'h0E);
      fwdB = 2'b00;

      // undefined opcode
      setop(alu_op_t'(4'hF), 32'd5, 32'd9, 0, 32'd0);
      #1 chk("badop_zeroE", 32'(zeroE), 32'd1);
      tick(); chk("badop_alu", alu_resultM, 32'd0);

      // store path
      memwriteE = 1; regwriteE = 0; RdE = 5'd0;
      setop(ALU_ADD, 32'h100, 32'hAB, 1, 32'd8);
      tick();
      chk("st_alu", alu_resultM, 32'h108);
      chk("st_wd", writedataM, 32'hAB);
      chk("st_memwrite", 32'(memwriteM), 32'd1);

      // stall holds for three cycles while E changes
      stallM = 1; memwriteE = 0; regwriteE = 1;
      for (int unsigned i = 0; i < 3; i++) begin
         RdE = 5'(i + 10);
         setop(ALU_ADD, 32'(i), 32'h33, 0, 32'd0);
         tick();
         chk("stall_alu", alu_resultM, 32'h108);
         chk("stall_memwrite", 32'(memwriteM), 32'd1);
      end
      stallM = 0;
      tick();
      chk("unstall_alu", alu_resultM, 32'h35);
      chk("unstall_rd", 32'(RdM), 32'd12);
      chk("unstall_regwrite", 32'(regwriteM), 32'd1);

      // flush beats stall
      stallM = 1; flushM = 1; regwriteE = 1; memwriteE = 1; RdE = 5'd9;
      tick();
      chk("flush_regwrite", 32'(regwriteM), 32'd0);
      chk("flush_memwrite", 32'(memwriteM), 32'd0);
      chk("flush_rd", 32'(RdM), 32'd0);
      chk("flush_alu", alu_resultM, 32'd0);

      // reload then reset beats stall
      stallM = 0; flushM = 0; resultsrcE = 1;
      setop(ALU_OR, 32'h5, 32'hA, 0, 32'd0);
      tick(); chk("reload_alu", alu_resultM, 32'hF);
      rst = 1; stallM = 1;
      tick();
      chk("rst_stall_alu", alu_resultM, 32'd0);
      chk("rst_stall_wd", writedataM, 32'd0);
      chk("rst_stall_rs", 32'(resultsrcM), 32'd0);
      chk("rst_stall_rw", 32'(regwriteM), 32'd0);
      rst = 0; stallM = 0;
      tick();
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
